lifo_stack_p: RTL and testbench

Parametrised successor to the team's fixed 16x16 stack. It is a synchronous LIFO with configurable width and depth, true element count (full means all DEPTH entries used), and simultaneous push/pop (replace-top). It also provides a synchronous clear, an almost-full threshold and sticky overflow/underflow error flags. It sits between the expression/control datapath and its operand producers, as the general-purpose hardware stack of the final design.

---
 rtl/lifo_pkg.sv | 17 +
 rtl/lifo_stack_p_if.sv | 42 ++++
 rtl/lifo_mem.sv | 38 +++
 rtl/lifo_stack_p.sv | 106 ++++++++++
 tb/tb_lifo_stack_p.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/lifo_pkg.sv
// Shared types and helpers for the parametrised LIFO stack.
package lifo_pkg;

   typedef enum logic [1:0] {
      OP_NOP,
      OP_PUSH,
      OP_POP,
      OP_REPL
   } lifo_op_t;

   localparam int EMPTY_RD = 0;

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/lifo_stack_p_if.sv
// Stack request/status bundle; optional peek port under LIFO_PEEK_EN.
interface lifo_stack_p_if #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_W      = 5
);
   logic                  clear;
   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] push_data;
   logic [DATA_WIDTH-1:0] top_data;
   logic [CNT_W-1:0]      count;
   logic                  empty;
   logic                  full;
   logic                  almost_full;
   logic                  overflow;
   logic                  underflow;
`ifdef LIFO_PEEK_EN
   logic [CNT_W-1:0]      peek_idx;
   logic [DATA_WIDTH-1:0] peek_data;
   logic                  peek_valid;
`endif

   modport master (
      output clear, push, pop, push_data,
`ifdef LIFO_PEEK_EN
      output peek_idx,
      input  peek_data, peek_valid,
`endif
      input  top_data, count, empty, full,
      input  almost_full, overflow, underflow
   );

   modport slave (
      input  clear, push, pop, push_data,
`ifdef LIFO_PEEK_EN
      input  peek_idx,
      output peek_data, peek_valid,
`endif
      output top_data, count, empty, full,
      output almost_full, overflow, underflow
   );
endinterface

// File: rtl/lifo_mem.sv
// Stack storage: one sync write port, combinational read port(s).
// Second read port exists only with LIFO_PEEK_EN.
module lifo_mem
   import lifo_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 16,
   parameter int CNT_W      = 5
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [CNT_W-1:0]      waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [CNT_W-1:0]      raddr,
   output logic [DATA_WIDTH-1:0] rdata
`ifdef LIFO_PEEK_EN
   ,
   input  logic [CNT_W-1:0]      paddr,
   output logic [DATA_WIDTH-1:0] pdata
`endif
);
   localparam logic [CNT_W-1:0] LIM = CNT_W'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we && waddr < LIM)
         mem[waddr] <= wdata;
   end

   // Out-of-range addresses read as the empty value, never X.
   assign rdata = (raddr < LIM) ? mem[raddr]
                                : DATA_WIDTH'(EMPTY_RD);
`ifdef LIFO_PEEK_EN
   assign pdata = (paddr < LIM) ? mem[paddr]
                                : DATA_WIDTH'(EMPTY_RD);
`endif
endmodule

// File: rtl/lifo_stack_p.sv
// Parametrised LIFO: op decode, count, sticky flags, output gating.
// Optional indexed peek read enabled by LIFO_PEEK_EN.
module lifo_stack_p
   import lifo_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = DEPTH - 2
) (
   input logic         clk,
   input logic         rst,
   lifo_stack_p_if.slave bus
);
   localparam int CNT_W = cnt_width(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      top_idx;
   logic [CNT_W-1:0]      waddr;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  ovf, unf;
   logic                  is_empty, is_full;
   logic                  go, we;
   logic                  ovf_set, unf_set;
   lifo_op_t              op;

   assign is_empty = (count == '0);
   assign is_full  = (count == FULL_CNT);
   assign top_idx  = count - ONE;
   assign go       = !rst && !bus.clear;

   // Push and pop together on an empty stack degrade to a push.
   always_comb begin
      op = OP_NOP;
      unique case (1'b1)
         go && bus.push && !bus.pop:
            op = is_full ? OP_NOP : OP_PUSH;
         go && !bus.push && bus.pop:
            op = is_empty ? OP_NOP : OP_POP;
         go && bus.push && bus.pop:
            op = is_empty ? OP_PUSH : OP_REPL;
         default: op = OP_NOP;
      endcase
   end

   assign ovf_set = go && bus.push && !bus.pop && is_full;
   assign unf_set = go && bus.pop && is_empty;
   assign we      = (op == OP_PUSH) || (op == OP_REPL);
   assign waddr   = (op == OP_REPL) ? top_idx : count;

   always_ff @(posedge clk) begin
      if (rst || bus.clear) begin
         count <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         unique case (op)
            OP_PUSH: count <= count + ONE;
            OP_POP:  count <= count - ONE;
            default: ;
         endcase
         if (ovf_set) ovf <= 1'b1;
         if (unf_set) unf <= 1'b1;
      end
   end

`ifdef LIFO_PEEK_EN
   logic [CNT_W-1:0]      paddr;
   logic [DATA_WIDTH-1:0] pdata;
   logic                  pvalid;

   assign pvalid = (bus.peek_idx < count);
   assign paddr  = top_idx - bus.peek_idx;
   assign bus.peek_valid = pvalid;
   assign bus.peek_data  = pvalid ? pdata
                                  : DATA_WIDTH'(EMPTY_RD);
`endif

   lifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .CNT_W      (CNT_W)
   ) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (bus.push_data),
      .raddr (top_idx),
      .rdata (rdata)
`ifdef LIFO_PEEK_EN
      ,
      .paddr (paddr),
      .pdata (pdata)
`endif
   );

   assign bus.top_data    = is_empty ? DATA_WIDTH'(EMPTY_RD)
                                     : rdata;
   assign bus.count       = count;
   assign bus.empty       = is_empty;
   assign bus.full        = is_full;
   assign bus.almost_full = (int'(count) >= AF_LEVEL);
   assign bus.overflow    = ovf;
   assign bus.underflow   = unf;
endmodule

// File: tb/tb_lifo_stack_p.sv
// Directed scoreboard bench for lifo_stack_p (DEPTH=4, AF_LEVEL=2).
module tb_lifo_stack_p;

   localparam int DW = 16;
   localparam int DEPTH = 4;
   localparam int AF = 2;
   localparam int CW = 3;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   lifo_stack_p_if #(.DATA_WIDTH(DW), .CNT_W(CW)) bus ();

   lifo_stack_p #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .AF_LEVEL   (AF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      int          due;
      string       nm;
      logic [CW-1:0] cnt;
      logic [DW-1:0] top;
      logic        ovf;
      logic        unf;
      bit          pk;
      logic        pv;
      logic [DW-1:0] pd;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic step(
      input bit          r,
      input bit          c,
      input bit          pu,
      input bit          po,
      input logic [DW-1:0] d,
      input logic [CW-1:0] ec,
      input logic [DW-1:0] et,
      input bit          eo,
      input bit          eu,
      input string       nm,
      input bit          pk = 1'b0,
      input logic [CW-1:0] pi = '0,
      input logic        pv = 1'b0,
      input logic [DW-1:0] pd = '0
   );
      exp_t e;
      @(negedge clk);
      rst = r;
      bus.clear = c;
      bus.push = pu;
      bus.pop = po;
      bus.push_data = d;
`ifdef LIFO_PEEK_EN
      bus.peek_idx = pi;
`endif
      e.due = cyc + 1;
      e.nm = nm;
      e.cnt = ec;
      e.top = et;
      e.ovf = eo;
      e.unf = eu;
      e.pk = pk;
      e.pv = pv;
      e.pd = pd;
      q.push_back(e);
   endtask

   // Monitor: compares every expectation that falls due this cycle.
   initial begin
      exp_t e;
      logic [DW+7:0] got, want;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.due < cyc) begin
               errors++;
               $display("FAIL %s stale due=%0d at=%0d",
                        e.nm, e.due, cyc);
            end else begin
               got = {bus.count, bus.top_data, bus.empty,
                      bus.full, bus.almost_full,
                      bus.overflow, bus.underflow};
               want = {e.cnt, e.top, e.cnt == 0,
                       e.cnt == CW'(DEPTH), e.cnt >= CW'(AF),
                       e.ovf, e.unf};
               if (got !== want) begin
                  errors++;
                  $display("FAIL %s got cnt=%0d top=%h e%b f%b af%b o%b u%b want cnt=%0d top=%h e%b f%b af%b o%b u%b",
                     e.nm, got[DW+7:DW+5], got[DW+4:5],
                     got[4], got[3], got[2], got[1], got[0],
                     want[DW+7:DW+5], want[DW+4:5],
                     want[4], want[3], want[2], want[1], want[0]);
               end
`ifdef LIFO_PEEK_EN
               if (e.pk) begin
                  checks++;
                  if (bus.peek_valid !== e.pv ||
                      bus.peek_data !== e.pd) begin
                     errors++;
                     $display("FAIL %s peek got v=%b d=%h want v=%b d=%h",
                        e.nm, bus.peek_valid, bus.peek_data,
                        e.pv, e.pd);
                  end
               end
`endif
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      bus.clear = 1'b0;
      bus.push = 1'b0;
      bus.pop = 1'b0;
      bus.push_data = '0;
`ifdef LIFO_PEEK_EN
      bus.peek_idx = '0;
`endif
      step(1, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0, "reset");
      step(0, 0, 1, 0, 16'h11, 1, 16'h11, 0, 0, "push1");
      step(0, 0, 1, 0, 16'h22, 2, 16'h22, 0, 0, "push2");
      step(0, 0, 1, 0, 16'h33, 3, 16'h33, 0, 0, "push3");
      step(0, 0, 1, 0, 16'h44, 4, 16'h44, 0, 0, "push4");
      step(0, 0, 1, 0, 16'h55, 4, 16'h44, 1, 0, "ovf");
      step(0, 0, 0, 1, 16'h0, 3, 16'h33, 1, 0, "pop1");
      step(0, 0, 0, 1, 16'h0, 2, 16'h22, 1, 0, "pop2");
      step(0, 0, 0, 1, 16'h0, 1, 16'h11, 1, 0, "pop3");
      step(0, 0, 0, 1, 16'h0, 0, 16'h0, 1, 0, "pop4");
      step(0, 0, 0, 1, 16'h0, 0, 16'h0, 1, 1, "unf");
      step(0, 0, 0, 0, 16'h0, 0, 16'h0, 1, 1, "idle");
      step(0, 1, 0, 0, 16'h0, 0, 16'h0, 0, 0, "clr1");
      step(0, 0, 1, 0, 16'h11, 1, 16'h11, 0, 0, "rp_a");
      step(0, 0, 1, 0, 16'h22, 2, 16'h22, 0, 0, "rp_b");
      step(0, 0, 1, 1, 16'hAA, 2, 16'hAA, 0, 0, "repl");
      step(0, 0, 0, 1, 16'h0, 1, 16'h11, 0, 0, "repl_pop");
      step(0, 1, 0, 0, 16'h0, 0, 16'h0, 0, 0, "clr2");
      step(0, 0, 1, 1, 16'h5A, 1, 16'h5A, 0, 1, "pp_empty");
      step(0, 0, 1, 0, 16'h66, 2, 16'h66, 0, 1, "f_a");
      step(0, 0, 1, 0, 16'h67, 3, 16'h67, 0, 1, "f_b");
      step(0, 0, 1, 0, 16'h68, 4, 16'h68, 0, 1, "f_c");
      step(0, 0, 1, 1, 16'h6F, 4, 16'h6F, 0, 1, "repl_full");
      step(0, 0, 1, 0, 16'h69, 4, 16'h6F, 1, 1, "ovf2");
      step(0, 0, 0, 1, 16'h0, 3, 16'h67, 1, 1, "to3");
      step(0, 1, 1, 0, 16'h99, 0, 16'h0, 0, 0, "clr_push");
      step(0, 0, 1, 0, 16'h77, 1, 16'h77, 0, 0, "push77");
      step(0, 0, 1, 0, 16'h12, 2, 16'h12, 0, 0, "push12");
      step(0, 0, 0, 1, 16'h0, 1, 16'h77, 0, 0, "pop12");
      step(0, 0, 0, 1, 16'h0, 0, 16'h0, 0, 0, "pop77");
      step(0, 0, 0, 1, 16'h0, 0, 16'h0, 0, 1, "unf2");
      step(1, 0, 1, 0, 16'h34, 0, 16'h0, 0, 0, "rst_push");
      step(0, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0, "post_rst");
`ifdef LIFO_PEEK_EN
      step(0, 0, 1, 0, 16'h11, 1, 16'h11, 0, 0, "pk_a");
      step(0, 0, 1, 0, 16'h22, 2, 16'h22, 0, 0, "pk_b");
      step(0, 0, 1, 0, 16'h33, 3, 16'h33, 0, 0, "pk_c");
      step(0, 0, 0, 0, 16'h0, 3, 16'h33, 0, 0, "peek2",
           1, 2, 1, 16'h11);
      step(0, 0, 0, 0, 16'h0, 3, 16'h33, 0, 0, "peek3",
           1, 3, 0, 16'h0);
      step(0, 0, 0, 0, 16'h0, 3, 16'h33, 0, 0, "peek0",
           1, 0, 1, 16'h33);
`endif
      @(negedge clk);
      rst = 1'b0;
      bus.clear = 1'b0;
      bus.push = 1'b0;
      bus.pop = 1'b0;
      repeat (3) @(negedge clk);
      while (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL %s never checked", q[0].nm);
         void'(q.pop_front());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
